// File: rtl/loop_pkg.sv
// Shared types and constants for the sample-period loop sequencer.
package loop_pkg;

  localparam int LOOP_DATA_W = 18;

  // PWM clamp limits, applied only in the LOOP_PWM_CLAMP_EN build
  localparam logic [LOOP_DATA_W-1:0] LOOP_PWM_MIN = '0;
  localparam logic [LOOP_DATA_W-1:0] LOOP_PWM_MAX = 18'h1FFFF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ADC_START,
    ADC_WAIT,
    LATCH,
    CPU_RST,
    CPU_RUN,
    PWM_UPD
  } loop_state_e;

endpackage

// File: rtl/period_timer.sv
// Free-running sample-period counter; tick marks the cycle in which the count wraps to 0.
module period_timer #(
  parameter int PERIOD_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  // Held at zero while disabled so the first period after enable is a full one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Sample-period sequencer: ADC conversion, operand latch, micro program run, PWM word update.
// Build macro LOOP_PWM_CLAMP_EN clamps the loaded PWM word (two's complement) to [0, PWM_MAX].
module loop_sequencer
  import loop_pkg::*;
#(
  parameter int PERIOD_CYCLES = 250000,
  parameter int ADC_TIMEOUT   = 4096,
  parameter int PROG_TIMEOUT  = 1024,
  parameter int DATA_W        = LOOP_DATA_W,
  parameter logic [DATA_W-1:0] PWM_MAX = DATA_W'(LOOP_PWM_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_ref,
  input  logic [DATA_W-1:0] adc_pot,
  output logic [DATA_W-1:0] ref_q,
  output logic [DATA_W-1:0] pot_q,
  output logic              cpu_rst_pc,
  output logic              cpu_run,
  input  logic              cpu_halt,
  input  logic [DATA_W-1:0] pwm_in,
  output logic [DATA_W-1:0] pwm_out,
  output logic              busy,
  output logic              overrun,
  output logic              fault,
  output loop_state_e       dbg_state
);

  localparam int TMO_MAX = (ADC_TIMEOUT > PROG_TIMEOUT) ? ADC_TIMEOUT : PROG_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);
  localparam logic [TMO_W-1:0] ADC_LAST  = TMO_W'(ADC_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] PROG_LAST = TMO_W'(PROG_TIMEOUT - 1);

`ifdef LOOP_PWM_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  loop_state_e       state, state_next;
  logic              tick;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_clear;
  logic              adc_timeout;
  logic              prog_timeout;
  logic              latch_en;
  logic              pwm_en;
  logic [DATA_W-1:0] pwm_next;

  period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_period_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  // Handshakes: adc_start and cpu_rst_pc are single-cycle requests; adc_done is honoured
  // only in ADC_WAIT and cpu_halt only in CPU_RUN, each bounded by its own timeout.
  always_comb begin
    state_next   = state;
    tmo_clear    = 1'b0;
    adc_timeout  = 1'b0;
    prog_timeout = 1'b0;
    latch_en     = 1'b0;
    pwm_en       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable)   state_next = IDLE;
        else if (tick) state_next = ADC_START;
      end
      ADC_START: begin
        tmo_clear  = 1'b1;
        state_next = ADC_WAIT;
      end
      ADC_WAIT: begin
        if (adc_done) begin
          state_next = LATCH;
        end else if (tmo_cnt == ADC_LAST) begin
          adc_timeout = 1'b1;
          state_next  = WAIT_TICK;
        end
      end
      LATCH: begin
        latch_en   = 1'b1;
        state_next = CPU_RST;
      end
      CPU_RST: begin
        tmo_clear  = 1'b1;
        state_next = CPU_RUN;
      end
      CPU_RUN: begin
        if (cpu_halt) begin
          state_next = PWM_UPD;
        end else if (tmo_cnt == PROG_LAST) begin
          prog_timeout = 1'b1;
          state_next   = WAIT_TICK;
        end
      end
      PWM_UPD: begin
        pwm_en     = 1'b1;
        state_next = enable ? WAIT_TICK : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (tmo_clear) begin
      tmo_cnt <= '0;
    end else if (state == ADC_WAIT || state == CPU_RUN) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    pwm_next = pwm_in;
    if (CLAMP_EN) begin
      if (pwm_in[DATA_W-1])      pwm_next = '0;
      else if (pwm_in > PWM_MAX) pwm_next = PWM_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q   <= '0;
      pot_q   <= '0;
      pwm_out <= '0;
      overrun <= 1'b0;
      fault   <= 1'b0;
    end else begin
      if (latch_en) begin
        ref_q <= adc_ref;
        pot_q <= adc_pot;
      end
      if (pwm_en) pwm_out <= pwm_next;
      // A tick that finds the sequence still running is dropped, not queued
      if (tick && busy) overrun <= 1'b1;
      if (adc_timeout || prog_timeout) fault <= 1'b1;
    end
  end

  // cpu_run falls combinationally with cpu_halt so the PC stops on the end instruction
  assign adc_start  = (state == ADC_START);
  assign cpu_rst_pc = (state == CPU_RST);
  assign cpu_run    = (state == CPU_RUN) && !cpu_halt;
  assign busy       = (state != IDLE) && (state != WAIT_TICK);
  assign dbg_state  = state;

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Sample-period scheduler for the ROM-driven control micro.
- Each period it does, in order: start an ADC conversion, latch REF/POT, reset and run the micro program, wait for the program's halt, then register the new PWM word.
- Replaces the free-running 5 ms PC reset with a handshaked sequence. Sits between the ADC front end, the micro's PC/register bank, and the PWM generator.

Parameters:
- PERIOD_CYCLES, 250000, clocks per sample period (5 ms at 50 MHz).
- ADC_TIMEOUT, 4096, max clocks to wait for adc_done.
- PROG_TIMEOUT, 1024, max clocks to wait for cpu_halt.
- DATA_W, 18, sample and PWM word width.
- PWM_MAX, 18'h1FFFF, upper clamp limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- enable  in  1  run the loop; when low, finish the current period, then idle
- adc_start  out  1  one-cycle conversion start pulse
- adc_done  in  1  conversion complete, level or pulse
- adc_ref  in  DATA_W  converted reference
- adc_pot  in  DATA_W  converted feedback
- ref_q  out  DATA_W  latched reference to the register bank
- pot_q  out  DATA_W  latched feedback to the register bank
- cpu_rst_pc  out  1  one-cycle PC reset pulse
- cpu_run  out  1  PC count enable
- cpu_halt  in  1  program reached its end instruction
- pwm_in  in  DATA_W  PWM word from the register bank
- pwm_out  out  DATA_W  registered PWM word
- busy  out  1  high in every state except IDLE and WAIT_TICK
- overrun  out  1  sticky: a period tick arrived while busy
- fault  out  1  sticky: ADC or program timeout

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0; state IDLE.
  - Period counter 0; timeout counter 0.
  - A mid-sequence reset abandons the sequence immediately; no pwm_out update occurs.
- Period counter:
  - Free-runs 0..PERIOD_CYCLES-1 whenever enable=1.
  - tick is asserted for one cycle when the count wraps to 0.
  - Held at 0 while enable=0.
- States and transitions:
  - IDLE: enable=1 -> WAIT_TICK.
  - WAIT_TICK: tick -> ADC_START; enable=0 -> IDLE.
  - ADC_START: adc_start=1 for exactly one cycle; clear timeout counter -> ADC_WAIT.
  - ADC_WAIT: adc_done=1 -> LATCH. Timeout counter reaching ADC_TIMEOUT -> set fault -> WAIT_TICK; ref_q, pot_q and pwm_out unchanged.
  - LATCH: ref_q<=adc_ref, pot_q<=adc_pot -> CPU_RST.
  - CPU_RST: cpu_rst_pc=1 for one cycle; clear timeout counter -> CPU_RUN.
  - CPU_RUN: cpu_run=1. cpu_halt=1 -> cpu_run drops the same cycle -> PWM_UPD. Timeout counter reaching PROG_TIMEOUT -> set fault, cpu_run=0 -> WAIT_TICK; pwm_out unchanged.
  - PWM_UPD: pwm_out<=pwm_in -> WAIT_TICK, or IDLE if enable=0.
- Latency:
  - tick to adc_start: 1 clk.
  - adc_done to cpu_rst_pc: 2 clk.
  - cpu_halt to new pwm_out: 2 clk.
- Tick arriving in any state other than WAIT_TICK: set overrun and drop that tick (no queuing). The next sequence starts on the following tick.
- cpu_halt sampled while not in CPU_RUN: ignored.
- adc_done sampled outside ADC_WAIT: ignored.
- Tick and enable=0 in the same cycle in WAIT_TICK: enable wins -> IDLE.
- overrun and fault are cleared only by reset.
- Timeout counters are wide enough for max(ADC_TIMEOUT, PROG_TIMEOUT); the period counter width is $clog2(PERIOD_CYCLES).

Optional Feature:
- Macro: LOOP_PWM_CLAMP_EN.
- Defined: pwm_in is treated as two's-complement DATA_W. PWM_UPD loads 0 if pwm_in<0, loads PWM_MAX if pwm_in>PWM_MAX, and otherwise loads pwm_in.
- Undefined: pwm_in is loaded verbatim; PWM_MAX is unused.

Decomposition:
- Shared package loop_pkg holds:
  - state enum (IDLE, WAIT_TICK, ADC_START, ADC_WAIT, LATCH, CPU_RST, CPU_RUN, PWM_UPD);
  - DATA_W default constant;
  - PWM clamp limits.
- One sub-module: period_timer (counter plus tick, with enable). Reused for any future sample-rate change.
- The FSM, latches and timeouts stay in loop_sequencer.

Test Plan:
- Nominal period (PERIOD_CYCLES=100, enable=1, adc_done 5 clk after adc_start, adc_ref=18'h00100, adc_pot=18'h000F0, cpu_halt 20 clk after cpu_rst_pc, pwm_in=18'h00010):
  - exactly one adc_start and one cpu_rst_pc per 100 clk;
  - ref_q=18'h00100, pot_q=18'h000F0;
  - pwm_out=18'h00010 two clk after cpu_halt;
  - overrun=0, fault=0.
- ADC timeout (adc_done never asserted, ADC_TIMEOUT=16): fault=1 after 16 clk in ADC_WAIT; no cpu_rst_pc; pwm_out holds its previous value; the next tick starts a new adc_start.
- Program overrun (cpu_halt delayed 150 clk, PERIOD_CYCLES=100, PROG_TIMEOUT=1024): overrun=1 at the 2nd tick; pwm_out updates once; the next adc_start aligns to the 3rd tick.
- Mid-sequence reset: rst low during CPU_RUN -> cpu_run=0, pwm_out=0, all flags 0 asynchronously; after release with enable=1, the first adc_start follows the first tick.
- enable dropped during ADC_WAIT: the sequence completes through PWM_UPD, then IDLE; no further adc_start for 3 periods.
- Clamp (LOOP_PWM_CLAMP_EN defined, PWM_MAX=18'h003FF):
  - pwm_in=18'h3FFF0 (negative) -> pwm_out=0;
  - pwm_in=18'h00500 -> pwm_out=18'h003FF;
  - macro undefined: pwm_in=18'h3FFF0 passes through unchanged.
